// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizes the serial line, detects the start
// edge, samples each bit at mid-period using the 16x oversample tick and
// hands the assembled word to the host over a valid/ack handshake.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 tick,
    output logic                 start_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [TW-1:0] TICK_HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE       = TW'(1);
    localparam logic [BW-1:0] BIT_LAST       = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE        = BW'(1);

    logic                 rx_sync1;
    logic                 rx_s;
    logic                 rx_prev;
    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS:0]   shift_next;

    // New sample enters at the top so the first bit received ends up as the LSB
    assign shift_next = {rx_s, shift_reg};

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= rx;
            rx_s     <= rx_sync1;
            rx_prev  <= rx_s;
        end
    end

    // Frame FSM with tick/bit counters, output word register and host handshake flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            start_rx      <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            start_rx      <= 1'b0;
            framing_error <= 1'b0;

            if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        start_rx <= 1'b1;
                        state    <= S_START;
                    end
                end

                S_START: begin
                    // The tick coinciding with start_rx belongs to the old phase
                    if (tick && !start_rx) begin
                        if (tick_cnt == TICK_HALF_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        if (tick_cnt == TICK_FULL_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= shift_next[DATA_BITS:1];
                            bit_cnt   <= bit_cnt + BIT_ONE;
                            if (bit_cnt == BIT_LAST) begin
                                state <= S_STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        if (tick_cnt == TICK_FULL_LAST) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                state <= S_IDLE;
                                if (rx_valid && !rx_ack) begin
                                    overrun <= 1'b1;
                                end else begin
                                    rx_data  <= shift_reg;
                                    rx_valid <= 1'b1;
                                end
                            end else begin
                                framing_error <= 1'b1;
                                state         <= S_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end
                end

                S_BREAK: begin
                    tick_cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    tick_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: frames are generated bit by
// bit from the word value, expected words go into a scoreboard queue and a
// monitor compares every word the DUT presents.
module tb_uart_rx_deserializer;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;
    localparam int DONE_TICKS = OVERSAMPLE / 2 + DATA_BITS * OVERSAMPLE + OVERSAMPLE;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 rx;
    logic                 tick;
    logic                 start_rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 framing_error;
    logic                 overrun;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_BITS-1:0] exp_q[$];
    int  n_start   = 0;
    int  n_ferr    = 0;
    int  exp_start = 0;
    int  exp_ferr  = 0;
    int  ticks_after_start = DONE_TICKS + 1;
    int  ack_req   = 0;
    int  ack_done  = 0;
    int  cack_req  = 0;
    int  cack_done = 0;
    int  lat_req   = 0;
    int  lat_done  = 0;
    bit  model_occupied = 1'b0;
    bit  model_overrun  = 1'b0;

    uart_rx_deserializer #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .tick         (tick),
        .start_rx     (start_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .framing_error(framing_error),
        .overrun      (overrun)
    );

    // Free-running system clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic sendBit(input logic b, input int clks);
        rx = b;
        repeat (clks) @(negedge clock);
    endtask

    // Sends one frame and updates the reference model of what the host should see
    task automatic applyStimulus(input logic [DATA_BITS-1:0] data, input bit stop_ok,
                                 input bit check_latency, input bit ack_on_done);
        logic s2;
        logic s3;
        exp_start++;
        if (stop_ok) begin
            if (!model_occupied || ack_on_done) begin
                exp_q.push_back(data);
                model_occupied = 1'b1;
                model_overrun  = 1'b0;
            end else begin
                model_overrun = 1'b1;
            end
        end else begin
            exp_ferr++;
        end
        if (ack_on_done) cack_req++;
        if (check_latency) lat_req++;

        rx = 1'b0;
        if (check_latency) begin
            @(negedge clock);
            @(negedge clock);
            s2 = start_rx;
            @(negedge clock);
            s3 = start_rx;
            checkOutput("start_rx_early", {31'd0, s2}, 32'd0);
            checkOutput("start_rx_latency3", {31'd0, s3}, 32'd1);
            repeat (BIT_CLKS - 3) @(negedge clock);
        end else begin
            repeat (BIT_CLKS) @(negedge clock);
        end
        for (int i = 0; i < DATA_BITS; i++) sendBit(data[i], BIT_CLKS);
        if (stop_ok) begin
            sendBit(1'b1, BIT_CLKS);
            sendBit(1'b1, 16);
        end else begin
            sendBit(1'b0, 40 * TICK_DIV);
            sendBit(1'b1, BIT_CLKS);
        end
    endtask

    // Issues one rx_ack pulse through the driver and checks the word is released
    task automatic ackWord();
        ack_req++;
        model_occupied = 1'b0;
        model_overrun  = 1'b0;
        for (int g = 0; g < 20 && ack_done != ack_req; g++) @(negedge clock);
        if (ack_done != ack_req) checkOutput("ack_issue_timeout", ack_done, ack_req);
        @(posedge clock);
        #1;
        checkOutput("valid_after_ack", {31'd0, rx_valid}, 32'd0);
        checkOutput("overrun_after_ack", {31'd0, overrun}, {31'd0, model_overrun});
        @(negedge clock);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        checkOutput({tag, "_start_rx"}, {31'd0, start_rx}, 32'd0);
        checkOutput({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        checkOutput({tag, "_framing"}, {31'd0, framing_error}, 32'd0);
        checkOutput({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    // Stimulus sequencer with the tick/ack driver and output monitor forked alongside
    initial begin
        reset  = 1'b1;
        rx     = 1'b1;
        tick   = 1'b0;
        rx_ack = 1'b0;

        fork
            begin : driver
                int phase;
                bit lat_pending;
                phase = 0;
                lat_pending = 1'b0;
                forever begin
                    @(negedge clock);
                    if (lat_pending) begin
                        checkOutput("valid_latency_after", {31'd0, rx_valid}, 32'd1);
                        lat_pending = 1'b0;
                    end
                    phase  = (phase + 1) % TICK_DIV;
                    tick   = (phase == 0);
                    rx_ack = 1'b0;
                    if (start_rx) begin
                        ticks_after_start = 0;
                    end else if (tick) begin
                        ticks_after_start++;
                        if (ticks_after_start == DONE_TICKS) begin
                            if (lat_req != lat_done) begin
                                lat_done++;
                                checkOutput("valid_latency_before", {31'd0, rx_valid}, 32'd0);
                                lat_pending = 1'b1;
                            end
                            if (cack_req != cack_done) begin
                                cack_done++;
                                rx_ack = 1'b1;
                            end
                        end
                    end
                    if (!rx_ack && ack_req != ack_done) begin
                        rx_ack = 1'b1;
                        ack_done++;
                    end
                end
            end
            begin : monitor
                bit prev_valid;
                prev_valid = 1'b0;
                forever begin
                    @(posedge clock);
                    #1;
                    if (start_rx) n_start++;
                    if (framing_error) n_ferr++;
                    if (rx_valid && (!prev_valid || rx_ack)) begin
                        if (exp_q.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("[TB] FAIL sb_unexpected_word: got 0x%0h, expected no word", rx_data);
                        end else begin
                            checkOutput("sb_word", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                        end
                    end
                    prev_valid = rx_valid;
                end
            end
        join_none

        repeat (3) @(negedge clock);
        checkResetValues("reset");
        reset = 1'b0;
        repeat (5) @(negedge clock);

        $display("[TB] basic frame 0xA5");
        applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0);
        checkOutput("a5_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("a5_data", {24'd0, rx_data}, 32'hA5);
        checkOutput("a5_overrun", {31'd0, overrun}, 32'd0);
        repeat (100) @(negedge clock);
        checkOutput("a5_valid_held", {31'd0, rx_valid}, 32'd1);
        checkOutput("a5_start_count", n_start, exp_start);
        checkOutput("a5_ferr_count", n_ferr, exp_ferr);
        ackWord();

        $display("[TB] start glitch then 0x3C");
        exp_start++;
        sendBit(1'b0, 3 * TICK_DIV);
        sendBit(1'b1, 120);
        checkOutput("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("glitch_start_count", n_start, exp_start);
        checkOutput("glitch_ferr_count", n_ferr, exp_ferr);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
        checkOutput("3c_valid", {31'd0, rx_valid}, 32'd1);
        ackWord();

        $display("[TB] framing error on 0x55 then 0x81");
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
        checkOutput("ferr_count", n_ferr, exp_ferr);
        checkOutput("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("break_start_count", n_start, exp_start);
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
        checkOutput("81_valid", {31'd0, rx_valid}, 32'd1);
        ackWord();

        $display("[TB] overrun 0x12 then 0x34");
        applyStimulus(8'h12, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h34, 1'b1, 1'b0, 1'b0);
        checkOutput("ovr_data_kept", {24'd0, rx_data}, 32'h12);
        checkOutput("ovr_flag", {31'd0, overrun}, {31'd0, model_overrun});
        checkOutput("ovr_valid", {31'd0, rx_valid}, 32'd1);
        ackWord();

        $display("[TB] ack on completion cycle");
        applyStimulus(8'h12, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h34, 1'b1, 1'b0, 1'b1);
        checkOutput("cack_issued", cack_done, cack_req);
        checkOutput("cack_data", {24'd0, rx_data}, 32'h34);
        checkOutput("cack_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("cack_overrun", {31'd0, overrun}, 32'd0);
        ackWord();

        $display("[TB] reset during data bit 4");
        exp_start += 2;
        sendBit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) sendBit(1'b0, BIT_CLKS);
        sendBit(1'b0, 10);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        checkResetValues("midreset");
        reset = 1'b0;
        model_occupied = 1'b0;
        model_overrun  = 1'b0;
        sendBit(1'b0, BIT_CLKS - 40);
        for (int i = 0; i < 3; i++) sendBit(1'b1, BIT_CLKS);
        sendBit(1'b1, 2 * BIT_CLKS);
        checkOutput("midreset_no_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("midreset_start_count", n_start, exp_start);
        applyStimulus(8'hF0, 1'b1, 1'b0, 1'b0);
        checkOutput("f0_valid", {31'd0, rx_valid}, 32'd1);
        ackWord();

        $display("[TB] random frames");
        for (int k = 0; k < 8; k++) begin
            logic [DATA_BITS-1:0] d;
            bit ok;
            d  = DATA_BITS'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            sendBit(1'b1, $urandom_range(1, 40));
            applyStimulus(d, ok, 1'b0, 1'b0);
            if (ok) begin
                checkOutput("rand_valid", {31'd0, rx_valid}, 32'd1);
                ackWord();
            end else begin
                checkOutput("rand_no_valid", {31'd0, rx_valid}, 32'd0);
            end
        end

        repeat (20) @(negedge clock);
        checkOutput("final_sb_empty", exp_q.size(), 32'd0);
        checkOutput("final_start_count", n_start, exp_start);
        checkOutput("final_ferr_count", n_ferr, exp_ferr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
